ibus_master: RTL and testbench

- IBUS initiator. Turns single host register accesses (byte/word/long, read/write) into IBUS transactions toward on-chip peripherals such as WDT, timers and SCI.
- Generates byte lanes and write-data replication, waits out IBUS_BUSY, extracts read data, and reports address errors and bus errors back to the host.
- Sits between the CPU-side access path and the shared IBUS fabric.

---
 rtl/ibus_master.sv | 181 ++++++++++++++++++
 tb/tb_ibus_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_master.sv
// ibus_master: IBUS initiator.
// Converts single host register accesses (byte/word/long, read/write) into
// IBUS transactions. It generates big-endian byte lanes, replicates write data
// across lanes, waits out IBUS_BUSY, extracts read data and reports address
// and bus errors back to the host.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   CE_R, CE_F         rising/falling phase clock enables (state moves on CE_R only)
//   HOST_A/DI/SZ/WE    host access description, sampled at acceptance
//   HOST_REQ           host request (level)
//   HOST_DO            last completed read data, right-justified, zero-extended
//   HOST_ACK/ERR       completion strobe and error status (one CE_R period)
//   IBUS_A/DO/BA/WE    bus address, write data, byte lanes ([3] = bits 31:24), write
//   IBUS_REQ           bus request
//   IBUS_DI            bus read data
//   IBUS_BUSY/ACT      responder wait and address-decoded indication
//
// Optional feature: define IBUS_MASTER_TIMEOUT_EN to abort an access after
// TIMEOUT busy CE_R periods. Without it a stuck IBUS_BUSY holds ACCESS until reset.

module ibus_master #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [27:0] HOST_A,
    input  logic [31:0] HOST_DI,
    input  logic [1:0]  HOST_SZ,
    input  logic        HOST_WE,
    input  logic        HOST_REQ,
    output logic [31:0] HOST_DO,
    output logic        HOST_ACK,
    output logic        HOST_ERR,
    output logic [27:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [1:0]  sz_q;
    logic [1:0]  off_q;
    logic [7:0]  wait_cnt;

    logic [3:0]  lanes;
    logic [31:0] wdata;
    logic        illegal;
    logic [31:0] rdata;

    // CE_F exists only for interface uniformity; TIMEOUT is idle in the default build.
    logic unused_ok;
    assign unused_ok = &{1'b0, CE_F, TIMEOUT};

    // Lane/data decode of the incoming request (used only at acceptance).
    always_comb begin
        lanes   = 4'b0000;
        wdata   = HOST_DI;
        illegal = 1'b0;
        case (HOST_SZ)
            2'b00: begin
                lanes = 4'b1000 >> HOST_A[1:0];
                wdata = {4{HOST_DI[7:0]}};
            end
            2'b01: begin
                lanes   = HOST_A[1] ? 4'b0011 : 4'b1100;
                wdata   = {2{HOST_DI[15:0]}};
                illegal = HOST_A[0];
            end
            2'b10: begin
                lanes   = 4'b1111;
                illegal = |HOST_A[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Read data extraction uses the latched size/offset, not the live host inputs.
    always_comb begin
        rdata = IBUS_DI;
        case (sz_q)
            2'b00: begin
                case (off_q)
                    2'd0:    rdata = {24'd0, IBUS_DI[31:24]};
                    2'd1:    rdata = {24'd0, IBUS_DI[23:16]};
                    2'd2:    rdata = {24'd0, IBUS_DI[15:8]};
                    default: rdata = {24'd0, IBUS_DI[7:0]};
                endcase
            end
            2'b01:   rdata = off_q[1] ? {16'd0, IBUS_DI[15:0]} : {16'd0, IBUS_DI[31:16]};
            default: rdata = IBUS_DI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            sz_q     <= 2'b00;
            off_q    <= 2'b00;
            wait_cnt <= 8'd0;
            HOST_DO  <= 32'd0;
            HOST_ACK <= 1'b0;
            HOST_ERR <= 1'b0;
            IBUS_A   <= 28'd0;
            IBUS_DO  <= 32'd0;
            IBUS_BA  <= 4'd0;
            IBUS_WE  <= 1'b0;
            IBUS_REQ <= 1'b0;
        end else if (CE_R) begin
            HOST_ACK <= 1'b0;
            HOST_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    // HOST_ACK=0 gate spaces back-to-back requests by one CE_R.
                    if (HOST_REQ && !HOST_ACK) begin
                        if (illegal) begin
                            HOST_ACK <= 1'b1;
                            HOST_ERR <= 1'b1;
                        end else begin
                            IBUS_A   <= HOST_A;
                            IBUS_WE  <= HOST_WE;
                            IBUS_REQ <= 1'b1;
                            IBUS_BA  <= lanes;
                            IBUS_DO  <= HOST_WE ? wdata : 32'd0;
                            sz_q     <= HOST_SZ;
                            off_q    <= HOST_A[1:0];
                            wait_cnt <= 8'd0;
                            state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!IBUS_ACT) begin
                        IBUS_REQ <= 1'b0;
                        IBUS_WE  <= 1'b0;
                        IBUS_BA  <= 4'd0;
                        HOST_ACK <= 1'b1;
                        HOST_ERR <= 1'b1;
                        state    <= IDLE;
                    end else if (IBUS_BUSY) begin
`ifdef IBUS_MASTER_TIMEOUT_EN
                        if (wait_cnt == TIMEOUT) begin
                            IBUS_REQ <= 1'b0;
                            IBUS_WE  <= 1'b0;
                            IBUS_BA  <= 4'd0;
                            HOST_ACK <= 1'b1;
                            HOST_ERR <= 1'b1;
                            state    <= IDLE;
                        end else if (wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
`else
                        if (wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
`endif
                    end else begin
                        if (!IBUS_WE) begin
                            HOST_DO <= rdata;
                        end
                        IBUS_REQ <= 1'b0;
                        IBUS_WE  <= 1'b0;
                        IBUS_BA  <= 4'd0;
                        HOST_ACK <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_master.sv
// Self-checking bench for ibus_master: directed cases plus randomized accesses
// compared against an arithmetic lane/data model.
module tb_ibus_master;

    logic        clk = 1'b0;
    logic        rst, ce_r, ce_f;
    logic [27:0] host_a;
    logic [31:0] host_di;
    logic [1:0]  host_sz;
    logic        host_we, host_req;
    logic [31:0] ibus_di;
    logic        ibus_busy, ibus_act;
    wire  [31:0] host_do;
    wire         host_ack, host_err;
    wire  [27:0] ibus_a;
    wire  [31:0] ibus_do;
    wire  [3:0]  ibus_ba;
    wire         ibus_we, ibus_req;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] prev_do;

    ibus_master #(.TIMEOUT(8'd4)) dut (
        .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f),
        .HOST_A(host_a), .HOST_DI(host_di), .HOST_SZ(host_sz), .HOST_WE(host_we),
        .HOST_REQ(host_req), .HOST_DO(host_do), .HOST_ACK(host_ack), .HOST_ERR(host_err),
        .IBUS_A(ibus_a), .IBUS_DO(ibus_do), .IBUS_DI(ibus_di), .IBUS_BA(ibus_ba),
        .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req), .IBUS_BUSY(ibus_busy), .IBUS_ACT(ibus_act)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One non-enabled edge (CE_F phase), then one CE_R edge; sample 1ns after it.
    task automatic ce_cycle();
        @(negedge clk); ce_r = 1'b0; ce_f = 1'b1;
        @(negedge clk); ce_r = 1'b1; ce_f = 1'b0;
        @(posedge clk); #1;
        ce_r = 1'b0;
    endtask

    // Access of n bytes at big-endian offset off occupies lanes starting at bit 8*(4-n-off).
    task automatic model(input logic [27:0] a, input logic [1:0] sz, input logic [31:0] wd_in,
                         input logic [31:0] bus_di, output bit ill, output logic [3:0] ba,
                         output logic [31:0] wd, output logic [31:0] rd);
        int n, off, sh;
        logic [31:0] m;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        ill = (sz == 2'd3) || ((off % n) != 0);
        ba = 4'd0; wd = 32'd0; rd = 32'd0;
        if (!ill) begin
            sh = 4 - n - off;
            m  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            ba = 4'(((1 << n) - 1) << sh);
            rd = (bus_di >> (8 * sh)) & m;
            for (int i = 0; i < 4 / n; i++) wd = wd | ((wd_in & m) << (8 * n * i));
        end
    endtask

    task automatic do_access(input logic [27:0] a, input logic [31:0] di, input logic [1:0] sz,
                             input bit we, input int busy, input bit act, input logic [31:0] bdi);
        bit          ill;
        logic [3:0]  eba;
        logic [31:0] ewd, erd;
        model(a, sz, di, bdi, ill, eba, ewd, erd);
        host_a = a; host_di = di; host_sz = sz; host_we = we; host_req = 1'b1;
        ibus_di = bdi; ibus_act = act; ibus_busy = (busy > 0);
        ce_cycle();
        // Scramble host inputs: they must not affect the access in progress.
        host_req = 1'b0; host_a = ~a; host_di = ~di; host_sz = ~sz; host_we = ~we;
        if (ill) begin
            check("ill_ack", 32'(host_ack), 32'd1);
            check("ill_err", 32'(host_err), 32'd1);
            check("ill_req", 32'(ibus_req), 32'd0);
        end else begin
            check("acc_req", 32'(ibus_req), 32'd1);
            check("acc_ba", 32'(ibus_ba), 32'(eba));
            check("acc_we", 32'(ibus_we), 32'(we));
            check("acc_a", {4'd0, ibus_a}, {4'd0, a});
            check("acc_do", ibus_do, we ? ewd : 32'd0);
            check("acc_ack0", 32'(host_ack), 32'd0);
            for (int k = 0; k <= busy; k++) begin
                ibus_busy = (k < busy);
                ce_cycle();
                if (!act) begin
                    check("berr_ack", 32'(host_ack), 32'd1);
                    check("berr_err", 32'(host_err), 32'd1);
                    check("berr_req", 32'(ibus_req), 32'd0);
                    check("berr_do", host_do, prev_do);
                    break;
                end
                if (k < busy) begin
                    check("wait_req", 32'(ibus_req), 32'd1);
                    check("wait_ack", 32'(host_ack), 32'd0);
                    check("wait_ba", 32'(ibus_ba), 32'(eba));
                end else begin
                    if (!we) prev_do = erd;
                    check("done_ack", 32'(host_ack), 32'd1);
                    check("done_err", 32'(host_err), 32'd0);
                    check("done_req", 32'(ibus_req), 32'd0);
                    check("done_ba", 32'(ibus_ba), 32'd0);
                    check("done_do", host_do, prev_do);
                end
            end
        end
        ibus_busy = 1'b0; ibus_act = 1'b1;
        ce_cycle();
        check("ack_clr", 32'(host_ack), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ce_r = 1'b0; ce_f = 1'b0;
        host_a = '0; host_di = '0; host_sz = '0; host_we = 1'b0; host_req = 1'b0;
        ibus_di = '0; ibus_busy = 1'b0; ibus_act = 1'b1;
        prev_do = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(ibus_req), 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_do", host_do, 32'd0);
        check("rst_ba", 32'(ibus_ba), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_access(28'h5FFFFB8, 32'h0000_5A10, 2'b01, 1'b1, 0, 1'b1, 32'h0);
        do_access(28'h5FFFFB9, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'hAA12_BBCC);
        do_access(28'h5FFFF80, 32'h0, 2'b10, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
        do_access(28'h5FFFFB9, 32'h0, 2'b01, 1'b0, 0, 1'b1, 32'h1234_5678);
        do_access(28'h5FFFFB8, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'h1234_5678);
        do_access(28'h5FFFFBA, 32'h0, 2'b01, 1'b0, 0, 1'b0, 32'h1111_2222);

        for (int i = 0; i < 40; i++) begin
            logic [27:0] ra;
            ra = 28'($urandom);
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            do_access(ra, $urandom, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), $urandom_range(0, 9) != 0, $urandom);
        end

        // Held request: refused while ACK is up, accepted on the following CE_R.
        host_a = 28'h0000_003; host_di = 32'h77; host_sz = 2'b00; host_we = 1'b1; host_req = 1'b1;
        ce_cycle();
        check("b2b_req1", 32'(ibus_req), 32'd1);
        ce_cycle();
        check("b2b_ack", 32'(host_ack), 32'd1);
        ce_cycle();
        check("b2b_gap_req", 32'(ibus_req), 32'd0);
        check("b2b_gap_ack", 32'(host_ack), 32'd0);
        ce_cycle();
        check("b2b_req2", 32'(ibus_req), 32'd1);
        check("b2b_ba2", 32'(ibus_ba), 32'h1);
        host_req = 1'b0;
        ce_cycle();
        check("b2b_ack2", 32'(host_ack), 32'd1);
        ce_cycle();

        // Stuck busy.
        host_a = 28'h100; host_sz = 2'b10; host_we = 1'b0; host_req = 1'b1; ibus_busy = 1'b1;
        ce_cycle();
        host_req = 1'b0;
        check("stk_req", 32'(ibus_req), 32'd1);
`ifdef IBUS_MASTER_TIMEOUT_EN
        for (int k = 1; k <= 5; k++) begin
            ce_cycle();
            if (k < 5) begin
                check("to_wait_ack", 32'(host_ack), 32'd0);
                check("to_wait_req", 32'(ibus_req), 32'd1);
            end else begin
                check("to_ack", 32'(host_ack), 32'd1);
                check("to_err", 32'(host_err), 32'd1);
                check("to_req", 32'(ibus_req), 32'd0);
            end
        end
        ce_cycle();
        host_req = 1'b1;
        ce_cycle();
        host_req = 1'b0;
        check("stk2_req", 32'(ibus_req), 32'd1);
`else
        for (int k = 0; k < 20; k++) begin
            ce_cycle();
            check("stk_hold_ack", 32'(host_ack), 32'd0);
            check("stk_hold_req", 32'(ibus_req), 32'd1);
        end
`endif
        // Reset mid-access on an edge without CE_R.
        ce_cycle();
        @(negedge clk); ce_r = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_req", 32'(ibus_req), 32'd0);
        check("mrst_ack", 32'(host_ack), 32'd0);
        check("mrst_do", host_do, 32'd0);
        prev_do = 32'd0;
        @(negedge clk); rst = 1'b0; ibus_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ce_cycle();
            check("mrst_noack", 32'(host_ack), 32'd0);
            check("mrst_noreq", 32'(ibus_req), 32'd0);
        end

        do_access(28'h5FFFFBB, 32'h0, 2'b00, 1'b0, 1, 1'b1, 32'h0102_0304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
